// File: rtl/pu_wb_sram_port_arbiter_if.sv
// rtl/pu_wb_sram_port_arbiter_if.sv - PU request/response and WB_SRAM read-port bundle
interface pu_wb_sram_port_arbiter_if #(
   parameter int NUM_PU = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int ID_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

   // PU controller side
   logic [NUM_PU-1:0]        pu_read;
   logic [NUM_PU*ADDR_W-1:0] pu_address;
   logic [NUM_PU-1:0]        pu_ready;
   logic [DATA_W-1:0]        pu_data;

   // Shared SRAM read port
   logic                     WB_SRAM_read;
   logic [ADDR_W-1:0]        WB_SRAM_address;
   logic                     WB_SRAM_ready;
   logic [DATA_W-1:0]        WB_SRAM_data;

   // Status
   logic [ID_W-1:0]          grant_id;
   logic                     timeout_err;

   // Arbiter view
   modport master (
      input  pu_read, pu_address, WB_SRAM_ready, WB_SRAM_data,
      output pu_ready, pu_data, WB_SRAM_read, WB_SRAM_address, grant_id, timeout_err
   );

   // PU controllers and SRAM view
   modport slave (
      output pu_read, pu_address, WB_SRAM_ready, WB_SRAM_data,
      input  pu_ready, pu_data, WB_SRAM_read, WB_SRAM_address, grant_id, timeout_err
   );
endinterface

// File: rtl/pu_wb_sram_port_arbiter.sv
// rtl/pu_wb_sram_port_arbiter.sv - round-robin sharing of one WB_SRAM read port among PU controllers
module pu_wb_sram_port_arbiter #(
   parameter int NUM_PU  = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   pu_wb_sram_port_arbiter_if.master bus
);
   localparam int ID_W   = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
   localparam int WDOG_W = 8;
   localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    pick_id, scan_idx;
   logic               pick_found;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               read_q, read_d;
   logic [NUM_PU-1:0]  ready_q, ready_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [WDOG_W-1:0]  wdog_q, wdog_d;
   logic               err_q, err_d;

   // Pick the first requester at or above rr_ptr, wrapping; index arithmetic wraps since NUM_PU is a power of two
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      scan_idx   = '0;
      for (int k = 0; k < NUM_PU; k++) begin
         scan_idx = rr_q + ID_W'(k);
         if (!pick_found && bus.pu_read[scan_idx]) begin
            pick_found = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   // Next state and next registered outputs; pu_ready defaults low so it can only ever pulse
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      read_d  = read_q;
      ready_d = '0;
      data_d  = data_q;
      wdog_d  = wdog_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            read_d = 1'b0;
            if (pick_found) begin
               state_d = ISSUE;
               grant_d = pick_id;
               rr_d    = pick_id + ID_W'(1);
               addr_d  = bus.pu_address[int'(pick_id)*ADDR_W +: ADDR_W];
               read_d  = 1'b1;
               wdog_d  = '0;
            end
         end
         ISSUE: begin
            read_d = 1'b1;
            if (bus.WB_SRAM_ready) begin
               data_d           = bus.WB_SRAM_data;
               ready_d[grant_q] = 1'b1;
               read_d           = 1'b0;
               state_d          = RESP;
            end else begin
               // Saturating watchdog; the error flag latches once the limit is hit
               if (wdog_q != WDOG_MAX) begin
                  wdog_d = wdog_q + WDOG_W'(1);
               end
               if (wdog_d == WDOG_MAX) begin
                  err_d = 1'b1;
               end
            end
         end
         RESP: begin
            read_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            read_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight transaction
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         read_q  <= 1'b0;
         ready_q <= '0;
         data_q  <= '0;
         wdog_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         read_q  <= read_d;
         ready_q <= ready_d;
         data_q  <= data_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
      end
   end

   assign bus.pu_ready        = ready_q;
   assign bus.pu_data         = data_q;
   assign bus.WB_SRAM_read    = read_q;
   assign bus.WB_SRAM_address = addr_q;
   assign bus.grant_id        = grant_q;
   assign bus.timeout_err     = err_q;
endmodule
